// File: rtl/scsi_dma_sm_if.sv
// SCSI DMA sequencer bus bundle.
// CPU, FIFO and SCSI-pin signals in one port.
interface scsi_dma_sm_if #(
  parameter int BUS_BYTES = 4,
  parameter int TC_W      = 24
);
  localparam int BOW = $clog2(BUS_BYTES);

  logic            CPUREQ;
  logic            RW;
  logic            AS_;
  logic            DMAENA;
  logic            DMADIR;
  logic            DREQ_;
  logic            FIFOFULL;
  logic            FIFOEMPTY;
  logic            BO_CLR;
  logic            TC_LOAD;
  logic [TC_W-1:0] TC_VAL;

  logic            SCSI_CS_o;
  logic            RE_o;
  logic            WE_o;
  logic            DACK_o;
  logic            S2F_o;
  logic            F2S_o;
  logic            S2CPU_o;
  logic            CPU2S_o;
  logic            INCBO_o;
  logic            INCNI_o;
  logic            INCNO_o;
  logic [BOW-1:0]  BO_o;
  logic            DSACK_o;
  logic            TC_ZERO;

  modport master (
    output CPUREQ, RW, AS_, DMAENA, DMADIR, DREQ_,
    output FIFOFULL, FIFOEMPTY, BO_CLR, TC_LOAD, TC_VAL,
    input  SCSI_CS_o, RE_o, WE_o, DACK_o, S2F_o, F2S_o,
    input  S2CPU_o, CPU2S_o, INCBO_o, INCNI_o, INCNO_o,
    input  BO_o, DSACK_o, TC_ZERO
  );

  modport slave (
    input  CPUREQ, RW, AS_, DMAENA, DMADIR, DREQ_,
    input  FIFOFULL, FIFOEMPTY, BO_CLR, TC_LOAD, TC_VAL,
    output SCSI_CS_o, RE_o, WE_o, DACK_o, S2F_o, F2S_o,
    output S2CPU_o, CPU2S_o, INCBO_o, INCNI_o, INCNO_o,
    output BO_o, DSACK_o, TC_ZERO
  );
endinterface

// File: rtl/scsi_dma_sm.sv
// SCSI transfer sequencer: CPU register cycles and
// DMA byte transfers with byte-lane and TC tracking.
module scsi_dma_sm #(
  parameter int BUS_BYTES  = 4,
  parameter int STROBE_CYC = 2,
  parameter int TC_W       = 24
) (
  input  logic         CPUCLK,
  input  logic         RESET_,
  scsi_dma_sm_if.slave bus
);
  localparam int BOW = $clog2(BUS_BYTES);
  localparam logic [3:0] SLOAD = 4'(STROBE_CYC - 1);
  localparam logic [BOW-1:0] BO_LAST = BOW'(BUS_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU_SETUP,
    CPU_STROBE,
    CPU_ACK,
    DMA_SETUP,
    DMA_STROBE,
    DMA_NEXT
  } state_e;

  state_e state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [BOW-1:0] bo_q, bo_d;
  logic [TC_W-1:0] tc_q, tc_d;
  logic dir_q, dir_d;
  logic rw_q, rw_d;
  logic tcz_q, tcz_d;
  logic creq_q, cas_q, cdreq_q;

  logic cs_q, cs_d;
  logic re_q, re_d;
  logic we_q, we_d;
  logic dack_q, dack_d;
  logic s2f_q, s2f_d;
  logic f2s_q, f2s_d;
  logic s2cpu_q, s2cpu_d;
  logic cpu2s_q, cpu2s_d;
  logic incbo_q, incbo_d;
  logic incni_q, incni_d;
  logic incno_q, incno_d;
  logic dsack_q, dsack_d;

  logic dma_go;
  logic dec;
  logic wrap;

  // Resynchronise the asynchronous CPU and SCSI request inputs.
  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) begin
      creq_q  <= 1'b0;
      cas_q   <= 1'b1;
      cdreq_q <= 1'b1;
    end else begin
      creq_q  <= bus.CPUREQ;
      cas_q   <= bus.AS_;
      cdreq_q <= bus.DREQ_;
    end
  end

  // Next state, strobe timing, byte-lane and counter updates.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    dir_d   = dir_q;
    rw_d    = rw_q;
    dec     = 1'b0;
    dma_go  = bus.DMAENA & ~cdreq_q & ~tcz_q &
              (bus.DMADIR ? ~bus.FIFOFULL : ~bus.FIFOEMPTY);
    unique case (state_q)
      IDLE: begin
        if (creq_q) begin
          state_d = CPU_SETUP;
          rw_d    = bus.RW;
        end else if (dma_go) begin
          state_d = DMA_SETUP;
          dir_d   = bus.DMADIR;
        end
      end
      CPU_SETUP: begin
        state_d = CPU_STROBE;
        scnt_d  = SLOAD;
      end
      CPU_STROBE: begin
        if (scnt_q == 4'd0) state_d = CPU_ACK;
        else scnt_d = scnt_q - 4'd1;
      end
      CPU_ACK: begin
        if (cas_q) state_d = IDLE;
      end
      DMA_SETUP: begin
        state_d = DMA_STROBE;
        scnt_d  = SLOAD;
      end
      DMA_STROBE: begin
        if (scnt_q == 4'd0) begin
          state_d = DMA_NEXT;
          dec     = 1'b1;
        end else begin
          scnt_d = scnt_q - 4'd1;
        end
      end
      DMA_NEXT: begin
        if (dma_go && !creq_q) begin
          state_d = DMA_SETUP;
          dir_d   = bus.DMADIR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lane and counter move on the edge that enters DMA_NEXT,
    // so DMA_NEXT already sees the decremented count.
    wrap = dec & (bo_q == BO_LAST) & ~bus.BO_CLR;
    if (bus.BO_CLR) bo_d = '0;
    else if (dec) bo_d = bo_q + BOW'(1);
    else bo_d = bo_q;

    if (bus.TC_LOAD) tc_d = bus.TC_VAL;
    else if (dec && tc_q != '0) tc_d = tc_q - TC_W'(1);
    else tc_d = tc_q;
    tcz_d = (tc_d == '0);

    cs_d    = (state_d == CPU_SETUP) | (state_d == CPU_STROBE);
    s2cpu_d = (state_d == CPU_STROBE) & rw_d;
    cpu2s_d = (state_d == CPU_STROBE) & ~rw_d;
    dack_d  = (state_d == DMA_SETUP) | (state_d == DMA_STROBE);
    s2f_d   = (state_d == DMA_STROBE) & dir_d;
    f2s_d   = (state_d == DMA_STROBE) & ~dir_d;
    re_d    = s2cpu_d | s2f_d;
    we_d    = cpu2s_d | f2s_d;
    dsack_d = (state_d != CPU_ACK);
    incbo_d = dec;
    incni_d = wrap & dir_q;
    incno_d = wrap & ~dir_q;
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q <= IDLE;
      scnt_q  <= 4'd0;
      bo_q    <= '0;
      tc_q    <= '0;
      tcz_q   <= 1'b1;
      dir_q   <= 1'b0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      dack_q  <= 1'b0;
      s2f_q   <= 1'b0;
      f2s_q   <= 1'b0;
      s2cpu_q <= 1'b0;
      cpu2s_q <= 1'b0;
      incbo_q <= 1'b0;
      incni_q <= 1'b0;
      incno_q <= 1'b0;
      dsack_q <= 1'b1;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bo_q    <= bo_d;
      tc_q    <= tc_d;
      tcz_q   <= tcz_d;
      dir_q   <= dir_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      re_q    <= re_d;
      we_q    <= we_d;
      dack_q  <= dack_d;
      s2f_q   <= s2f_d;
      f2s_q   <= f2s_d;
      s2cpu_q <= s2cpu_d;
      cpu2s_q <= cpu2s_d;
      incbo_q <= incbo_d;
      incni_q <= incni_d;
      incno_q <= incno_d;
      dsack_q <= dsack_d;
    end
  end

  assign bus.SCSI_CS_o = cs_q;
  assign bus.RE_o      = re_q;
  assign bus.WE_o      = we_q;
  assign bus.DACK_o    = dack_q;
  assign bus.S2F_o     = s2f_q;
  assign bus.F2S_o     = f2s_q;
  assign bus.S2CPU_o   = s2cpu_q;
  assign bus.CPU2S_o   = cpu2s_q;
  assign bus.INCBO_o   = incbo_q;
  assign bus.INCNI_o   = incni_q;
  assign bus.INCNO_o   = incno_q;
  assign bus.BO_o      = bo_q;
  assign bus.DSACK_o   = dsack_q;
  assign bus.TC_ZERO   = tcz_q;
endmodule

// File: tb/tb_scsi_dma_sm.sv
// Bench for scsi_dma_sm: random CPU/DMA traffic,
// per-byte and per-cycle scoreboards.
module tb_scsi_dma_sm;
  localparam int BB  = 4;
  localparam int SC  = 2;
  localparam int TW  = 24;
  localparam int BOW = $clog2(BB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scsi_dma_sm_if #(.BUS_BYTES(BB), .TC_W(TW)) bus ();

  scsi_dma_sm #(
    .BUS_BYTES (BB),
    .STROBE_CYC(SC),
    .TC_W      (TW)
  ) dut (
    .CPUCLK(clk),
    .RESET_(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic           dir;
    logic [BOW-1:0] bo;
    logic           ni;
    logic           no;
  } dexp_t;

  dexp_t dq[$];
  logic  cq[$];
  int    model_bo = 0;
  int    vecs = 0;
  int    errs = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: each byte advances the lane modulo BB; a word
  // completes when the lane wraps unless a clear overrides it.
  function automatic void exp_byte(logic dir, logic clr);
    dexp_t e;
    e.dir = dir;
    if (clr) begin
      e.ni = 1'b0;
      e.no = 1'b0;
      model_bo = 0;
    end else begin
      e.ni = dir && (model_bo == BB - 1);
      e.no = !dir && (model_bo == BB - 1);
      model_bo = (model_bo + 1) % BB;
    end
    e.bo = model_bo[BOW-1:0];
    dq.push_back(e);
  endfunction

  // Monitor: measure strobes and compare on each completion.
  int dack_n, re_n, we_n, cs_n, cre_n, cwe_n;
  logic pdsack = 1'b1;
  dexp_t me;
  logic  mrw;
  always @(negedge clk) begin
    if (!rst_n) begin
      dack_n = 0; re_n = 0; we_n = 0;
      cs_n = 0; cre_n = 0; cwe_n = 0;
      pdsack = 1'b1;
    end else begin
      if (bus.DACK_o) dack_n++;
      if (bus.RE_o && bus.S2F_o) re_n++;
      if (bus.WE_o && bus.F2S_o) we_n++;
      if (bus.SCSI_CS_o) cs_n++;
      if (bus.RE_o && bus.S2CPU_o) cre_n++;
      if (bus.WE_o && bus.CPU2S_o) cwe_n++;
      if (bus.INCBO_o) begin
        if (dq.size() == 0) begin
          chk("dma_unexpected_byte", 1, 0);
        end else begin
          me = dq.pop_front();
          chk("dma_bo", 32'(bus.BO_o), 32'(me.bo));
          chk("dma_incni", 32'(bus.INCNI_o), 32'(me.ni));
          chk("dma_incno", 32'(bus.INCNO_o), 32'(me.no));
          chk("dma_dack_len", dack_n, SC + 1);
          chk("dma_strobe_len", me.dir ? re_n : we_n, SC);
          chk("dma_wrong_strobe", me.dir ? we_n : re_n, 0);
        end
        dack_n = 0; re_n = 0; we_n = 0;
      end
      if (pdsack && !bus.DSACK_o) begin
        if (cq.size() == 0) begin
          chk("cpu_unexpected_ack", 1, 0);
        end else begin
          mrw = cq.pop_front();
          chk("cpu_cs_len", cs_n, SC + 1);
          chk("cpu_strobe_len", mrw ? cre_n : cwe_n, SC);
          chk("cpu_wrong_strobe", mrw ? cwe_n : cre_n, 0);
        end
        cs_n = 0; cre_n = 0; cwe_n = 0;
      end
      pdsack = bus.DSACK_o;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tc(int v);
    bus.TC_LOAD = 1'b1;
    bus.TC_VAL  = TW'(v);
    cyc(1);
    bus.TC_LOAD = 1'b0;
  endtask

  task automatic clr_bo();
    bus.BO_CLR = 1'b1;
    cyc(1);
    bus.BO_CLR = 1'b0;
    model_bo = 0;
  endtask

  task automatic wait_dq(string nm);
    int i = 0;
    while (dq.size() != 0 && i < 400) begin
      cyc(1);
      i++;
    end
    chk(nm, dq.size(), 0);
  endtask

  task automatic wait_incbo(int k);
    int i = 0;
    int c = 0;
    while (c < k && i < 200) begin
      cyc(1);
      i++;
      if (bus.INCBO_o) c++;
    end
    chk("incbo_wait_timeout", c, k);
  endtask

  task automatic wait_strobe(int k);
    int i = 0;
    int c = 0;
    logic p = 1'b0;
    while (c < k && i < 200) begin
      cyc(1);
      i++;
      if (bus.RE_o && !p) c++;
      p = bus.RE_o;
    end
    chk("strobe_wait_timeout", c, k);
  endtask

  task automatic cpu_cycle(logic rw);
    int i = 0;
    bus.CPUREQ = 1'b1;
    bus.RW     = rw;
    bus.AS_    = 1'b0;
    cq.push_back(rw);
    while (bus.DSACK_o !== 1'b0 && i < 100) begin
      cyc(1);
      i++;
    end
    chk("cpu_dsack_timeout", 32'(i < 100), 1);
    bus.CPUREQ = 1'b0;
    bus.AS_    = 1'b1;
    i = 0;
    while (bus.DSACK_o !== 1'b1 && i < 20) begin
      cyc(1);
      i++;
    end
    chk("cpu_dsack_release", 32'(bus.DSACK_o), 1);
  endtask

  task automatic idle_inputs();
    bus.CPUREQ = 1'b0;  bus.RW = 1'b0;
    bus.AS_ = 1'b1;     bus.DMAENA = 1'b0;
    bus.DMADIR = 1'b0;  bus.DREQ_ = 1'b1;
    bus.FIFOFULL = 1'b0; bus.FIFOEMPTY = 1'b0;
    bus.BO_CLR = 1'b0;  bus.TC_LOAD = 1'b0;
    bus.TC_VAL = '0;
  endtask

  initial begin
    int n, k, b0;
    logic dir, cause, rw;
    idle_inputs();
    cyc(2);
    chk("rst_cs", 32'(bus.SCSI_CS_o), 0);
    chk("rst_re", 32'(bus.RE_o), 0);
    chk("rst_we", 32'(bus.WE_o), 0);
    chk("rst_dack", 32'(bus.DACK_o), 0);
    chk("rst_dsack", 32'(bus.DSACK_o), 1);
    chk("rst_tczero", 32'(bus.TC_ZERO), 1);
    chk("rst_bo", 32'(bus.BO_o), 0);
    rst_n = 1'b1;
    cyc(2);

    // CPU read cycle timing
    bus.CPUREQ = 1'b1;
    bus.RW = 1'b1;
    bus.AS_ = 1'b0;
    cq.push_back(1'b1);
    for (int c = 1; c <= SC + 5; c++) begin
      cyc(1);
      chk($sformatf("cpurd_cs_c%0d", c), 32'(bus.SCSI_CS_o),
          32'(c >= 2 && c <= SC + 2));
      chk($sformatf("cpurd_re_c%0d", c), 32'(bus.RE_o & bus.S2CPU_o),
          32'(c >= 3 && c <= SC + 2));
      chk($sformatf("cpurd_dsack_c%0d", c), 32'(bus.DSACK_o),
          32'(c < SC + 3));
    end
    bus.CPUREQ = 1'b0;
    bus.AS_ = 1'b1;
    cyc(3);
    chk("cpurd_dsack_release", 32'(bus.DSACK_o), 1);

    for (int i = 0; i < 6; i++) cpu_cycle(1'($urandom % 2));

    // S2F burst of 8 with DREQ held
    clr_bo();
    load_tc(8);
    bus.DMADIR = 1'b1;
    bus.DMAENA = 1'b1;
    for (int i = 0; i < 8; i++) exp_byte(1'b1, 1'b0);
    bus.DREQ_ = 1'b0;
    wait_dq("s2f8_drain");
    cyc(4);
    chk("s2f8_tczero", 32'(bus.TC_ZERO), 1);
    chk("s2f8_idle", 32'(bus.DACK_o), 0);
    chk("s2f8_bo", 32'(bus.BO_o), 0);
    bus.DREQ_ = 1'b1;

    // Random bursts stalled by FIFO flag or DMAENA
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(3, 10);
      k = $urandom_range(1, n - 1);
      dir = 1'($urandom % 2);
      cause = 1'($urandom % 2);
      b0 = model_bo;
      load_tc(n);
      bus.DMADIR = dir;
      bus.DMAENA = 1'b1;
      for (int i = 0; i < n; i++) exp_byte(dir, 1'b0);
      bus.DREQ_ = 1'b0;
      wait_incbo(k);
      if (cause) bus.DMAENA = 1'b0;
      else if (dir) bus.FIFOFULL = 1'b1;
      else bus.FIFOEMPTY = 1'b1;
      cyc(6);
      chk("stall_dack", 32'(bus.DACK_o), 0);
      chk("stall_bo", 32'(bus.BO_o), 32'((b0 + k) % BB));
      chk("stall_pending", dq.size(), n - k);
      chk("stall_tczero", 32'(bus.TC_ZERO), 0);
      if ($urandom % 2) cpu_cycle(1'($urandom % 2));
      bus.DMAENA = 1'b1;
      bus.FIFOFULL = 1'b0;
      bus.FIFOEMPTY = 1'b0;
      wait_dq("stall_drain");
      cyc(4);
      chk("stall_end_tczero", 32'(bus.TC_ZERO), 1);
      bus.DREQ_ = 1'b1;
    end

    // CPU request in the middle of a burst
    dir = 1'($urandom % 2);
    rw = 1'($urandom % 2);
    load_tc(8);
    bus.DMADIR = dir;
    bus.DMAENA = 1'b1;
    for (int i = 0; i < 8; i++) exp_byte(dir, 1'b0);
    bus.DREQ_ = 1'b0;
    wait_incbo(3);
    cpu_cycle(rw);
    wait_dq("cpumid_drain");
    cyc(4);
    chk("cpumid_tczero", 32'(bus.TC_ZERO), 1);
    bus.DREQ_ = 1'b1;

    // Lane clear and count reload on the wrapping byte
    clr_bo();
    load_tc(4);
    bus.DMADIR = 1'b1;
    bus.DMAENA = 1'b1;
    for (int i = 0; i < 3; i++) exp_byte(1'b1, 1'b0);
    exp_byte(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) exp_byte(1'b1, 1'b0);
    bus.DREQ_ = 1'b0;
    wait_strobe(4);
    cyc(SC - 1);
    bus.BO_CLR = 1'b1;
    bus.TC_LOAD = 1'b1;
    bus.TC_VAL = TW'(3);
    cyc(1);
    bus.BO_CLR = 1'b0;
    bus.TC_LOAD = 1'b0;
    wait_dq("clrload_drain");
    cyc(4);
    chk("clrload_tczero", 32'(bus.TC_ZERO), 1);
    chk("clrload_bo", 32'(bus.BO_o), 3);
    bus.DREQ_ = 1'b1;

    // Reset in the middle of a DMA strobe
    clr_bo();
    load_tc(5);
    bus.DMADIR = 1'b1;
    for (int i = 0; i < 5; i++) exp_byte(1'b1, 1'b0);
    bus.DREQ_ = 1'b0;
    wait_strobe(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_re", 32'(bus.RE_o), 0);
    chk("arst_dack", 32'(bus.DACK_o), 0);
    chk("arst_bo", 32'(bus.BO_o), 0);
    chk("arst_tczero", 32'(bus.TC_ZERO), 1);
    chk("arst_dsack", 32'(bus.DSACK_o), 1);
    dq.delete();
    model_bo = 0;
    bus.DREQ_ = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("arst_stays_idle", 32'(bus.DACK_o), 0);
    cpu_cycle(1'b0);
    cyc(2);
    chk("cpu_queue_drained", cq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
